bumper_collision_detector: RTL

BUMPER_COLLISION_DETECTOR -- requirements
Module: bumper_collision_detector

---
 rtl/bumper_collision_detector_pkg.sv | 14 +
 rtl/bumper_priority_encoder.sv | 26 ++
 rtl/bumper_collision_detector.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bumper_collision_detector_pkg.sv
// Shared types and default parameter values for the bumper collision detector.
package bumper_collision_detector_pkg;

    typedef enum logic {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_NUM_BUMPERS     = 4;
    localparam int unsigned DEFAULT_COOLDOWN_FRAMES = 30;
    localparam int unsigned DEFAULT_HIT_COUNT_W     = 8;
    localparam int unsigned COOLDOWN_CNT_W          = 8;

endpackage

// File: rtl/bumper_priority_encoder.sv
// Combinational lowest-index selector over the bumper drawing requests.
module bumper_priority_encoder #(
    parameter int unsigned NUM_BUMPERS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_BUMPERS)
) (
    input  logic [NUM_BUMPERS-1:0] req,
    output logic                   valid,
    output logic [IDX_W-1:0]       index
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        index = {IDX_W{1'b0}};
        for (int i = NUM_BUMPERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = i[IDX_W-1:0];
            end else begin
                valid = valid;
                index = index;
            end
        end
    end

endmodule

// File: rtl/bumper_collision_detector.sv
// Detects ship/bumper pixel overlap per frame and reports at most one hit
// per frame at the following frame start, followed by a frame-count cooldown.
module bumper_collision_detector
    import bumper_collision_detector_pkg::*;
#(
    parameter int unsigned NUM_BUMPERS     = DEFAULT_NUM_BUMPERS,
    parameter int unsigned COOLDOWN_FRAMES = DEFAULT_COOLDOWN_FRAMES,
    parameter int unsigned HIT_COUNT_W     = DEFAULT_HIT_COUNT_W,
    parameter int unsigned IDX_W           = $clog2(NUM_BUMPERS)
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   shipDrawingRequest,
    input  logic [NUM_BUMPERS-1:0] bumperDrawingRequest,
    output logic                   collision,
    output logic [IDX_W-1:0]       hitIndex,
    output logic [HIT_COUNT_W-1:0] hitCount,
    output logic                   cooldownActive
);

    state_e                    state_r, state_next_s;
    logic                      frame_hit_r, frame_hit_next_s;
    logic [IDX_W-1:0]          latched_idx_r, latched_idx_next_s;
    logic [COOLDOWN_CNT_W-1:0] cooldown_cnt_r, cooldown_cnt_next_s;
    logic                      collision_r, collision_next_s;
    logic [IDX_W-1:0]          hit_index_r, hit_index_next_s;
    logic [HIT_COUNT_W-1:0]    hit_count_r, hit_count_next_s;
    logic                      cooldown_active_r;
    logic                      enc_valid_s;
    logic [IDX_W-1:0]          enc_idx_s;
    logic                      overlap_s;

    bumper_priority_encoder #(
        .NUM_BUMPERS (NUM_BUMPERS),
        .IDX_W       (IDX_W)
    ) u_prio (
        .req   (bumperDrawingRequest),
        .valid (enc_valid_s),
        .index (enc_idx_s)
    );

    assign overlap_s = shipDrawingRequest & enc_valid_s;

    // Next-state and output decode; all outputs move only on startOfFrame.
    always_comb begin
        state_next_s        = state_r;
        frame_hit_next_s    = frame_hit_r;
        latched_idx_next_s  = latched_idx_r;
        cooldown_cnt_next_s = cooldown_cnt_r;
        collision_next_s    = 1'b0;
        hit_index_next_s    = hit_index_r;
        hit_count_next_s    = hit_count_r;

        if (startOfFrame) begin
            case (state_r)
                ARMED: begin
                    if (frame_hit_r) begin
                        collision_next_s    = 1'b1;
                        hit_index_next_s    = latched_idx_r;
                        cooldown_cnt_next_s = COOLDOWN_CNT_W'(COOLDOWN_FRAMES);
                        state_next_s        = COOLDOWN;
                        if (hit_count_r != {HIT_COUNT_W{1'b1}}) begin
                            hit_count_next_s = hit_count_r + HIT_COUNT_W'(1);
                        end else begin
                            hit_count_next_s = hit_count_r;
                        end
                    end else begin
                        state_next_s = ARMED;
                    end
                end
                COOLDOWN: begin
                    cooldown_cnt_next_s = cooldown_cnt_r - COOLDOWN_CNT_W'(1);
                    if (cooldown_cnt_r == COOLDOWN_CNT_W'(1)) begin
                        state_next_s = ARMED;
                    end else begin
                        state_next_s = COOLDOWN;
                    end
                end
                default: begin
                    state_next_s = ARMED;
                end
            endcase
            // A same-cycle overlap belongs to the new frame, judged by the new state.
            if (overlap_s && (state_next_s == ARMED)) begin
                frame_hit_next_s   = 1'b1;
                latched_idx_next_s = enc_idx_s;
            end else begin
                frame_hit_next_s = 1'b0;
            end
        end else begin
            if (overlap_s && (state_r == ARMED) && !frame_hit_r) begin
                frame_hit_next_s   = 1'b1;
                latched_idx_next_s = enc_idx_s;
            end else begin
                frame_hit_next_s = frame_hit_r;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r           <= ARMED;
            frame_hit_r       <= 1'b0;
            latched_idx_r     <= {IDX_W{1'b0}};
            cooldown_cnt_r    <= {COOLDOWN_CNT_W{1'b0}};
            collision_r       <= 1'b0;
            hit_index_r       <= {IDX_W{1'b0}};
            hit_count_r       <= {HIT_COUNT_W{1'b0}};
            cooldown_active_r <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            frame_hit_r       <= frame_hit_next_s;
            latched_idx_r     <= latched_idx_next_s;
            cooldown_cnt_r    <= cooldown_cnt_next_s;
            collision_r       <= collision_next_s;
            hit_index_r       <= hit_index_next_s;
            hit_count_r       <= hit_count_next_s;
            cooldown_active_r <= (state_next_s == COOLDOWN);
        end
    end

    assign collision      = collision_r;
    assign hitIndex       = hit_index_r;
    assign hitCount       = hit_count_r;
    assign cooldownActive = cooldown_active_r;

endmodule
